// File: rtl/seq_11010_tx_if.sv
// Request and serial-output bundle between a pattern requester (master)
// and the seq_11010_tx transmitter (slave).
interface seq_11010_tx_if #(
   parameter int WIDTH = 5,
   parameter int REP_W = 4
);
   logic             start;
   logic [WIDTH-1:0] pattern;
   logic [REP_W-1:0] reps;
   logic             abort;
   logic             a_out;
   logic             bit_valid;
   logic             busy;
   logic             done;

   modport master (
      output start, pattern, reps, abort,
      input  a_out, bit_valid, busy, done
   );

   modport slave (
      input  start, pattern, reps, abort,
      output a_out, bit_valid, busy, done
   );
endinterface

// File: rtl/seq_11010_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first,
// repeated a programmable number of times with a fixed idle gap between copies.
module seq_11010_tx #(
   parameter int WIDTH      = 5,
   parameter int REP_W      = 4,
   parameter int GAP_CYCLES = 2
) (
   input logic           clk,
   input logic           reset_n,
   seq_11010_tx_if.slave bus
);
   localparam int BIT_W = $clog2(WIDTH);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [WIDTH-1:0] PAT_ZERO = {WIDTH{1'b0}};
   localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
   localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
   localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
   localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      GAP  = 2'b10,
      FIN  = 2'b11
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] pat_r;
   logic [BIT_W-1:0] bit_cnt_r;
   logic [REP_W-1:0] rep_cnt_r;
   logic [GAP_W-1:0] gap_cnt_r;
   logic             a_out_r;
   logic             bit_valid_r;
   logic             busy_r;
   logic             done_r;

   assign bus.a_out     = a_out_r;
   assign bus.bit_valid = bit_valid_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;

   // Transmit FSM; outputs are registered for the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         shift_r     <= PAT_ZERO;
         pat_r       <= PAT_ZERO;
         bit_cnt_r   <= BIT_ZERO;
         rep_cnt_r   <= REP_ZERO;
         gap_cnt_r   <= GAP_ZERO;
         a_out_r     <= 1'b0;
         bit_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         // Outputs default low; each branch raises what its next state shows.
         a_out_r     <= 1'b0;
         bit_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start && (bus.reps != REP_ZERO)) begin
                  state_r     <= SEND;
                  shift_r     <= bus.pattern;
                  pat_r       <= bus.pattern;
                  rep_cnt_r   <= bus.reps;
                  bit_cnt_r   <= BIT_LAST;
                  a_out_r     <= bus.pattern[WIDTH-1];
                  bit_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
               end else if (bus.start) begin
                  state_r <= FIN;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            SEND: begin
               if (bus.abort) begin
                  state_r <= IDLE;
               end else if (bit_cnt_r != BIT_ZERO) begin
                  shift_r     <= {shift_r[WIDTH-2:0], 1'b0};
                  bit_cnt_r   <= bit_cnt_r - BIT_ONE;
                  a_out_r     <= shift_r[WIDTH-2];
                  bit_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
               end else begin
                  if (rep_cnt_r != REP_ZERO) begin
                     rep_cnt_r <= rep_cnt_r - REP_ONE;
                  end else begin
                     rep_cnt_r <= REP_ZERO;
                  end
                  busy_r <= 1'b1;
                  // More than one copy left before the decrement means another pattern follows.
                  if (rep_cnt_r > REP_ONE) begin
                     if (GAP_CYCLES > 0) begin
                        state_r   <= GAP;
                        gap_cnt_r <= GAP_LOAD;
                     end else begin
                        state_r     <= SEND;
                        shift_r     <= pat_r;
                        bit_cnt_r   <= BIT_LAST;
                        a_out_r     <= pat_r[WIDTH-1];
                        bit_valid_r <= 1'b1;
                     end
                  end else begin
                     state_r <= FIN;
                     done_r  <= 1'b1;
                  end
               end
            end
            GAP: begin
               if (bus.abort) begin
                  state_r <= IDLE;
               end else if (gap_cnt_r != GAP_ZERO) begin
                  gap_cnt_r <= gap_cnt_r - GAP_ONE;
                  busy_r    <= 1'b1;
               end else begin
                  state_r     <= SEND;
                  shift_r     <= pat_r;
                  bit_cnt_r   <= BIT_LAST;
                  a_out_r     <= pat_r[WIDTH-1];
                  bit_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
               end
            end
            FIN: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_11010_tx.sv
// Bench for seq_11010_tx: a GAP_CYCLES=2 and a GAP_CYCLES=0 instance share
// stimulus; a per-cycle expected-output queue is built from the frame rules.
module tb_seq_11010_tx;
   localparam int W  = 5;
   localparam int RW = 4;

   typedef logic [3:0] obs_t;            // {a_out, bit_valid, busy, done}
   typedef obs_t obs_q_t[$];
   typedef struct {
      logic          st;
      logic [W-1:0]  pat;
      logic [RW-1:0] rp;
      logic          ab;
      obs_t          exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          abort;
   logic [W-1:0]  pattern;
   logic [RW-1:0] reps;
   int            n_cmp  = 0;
   int            n_err  = 0;
   int            edge_n = 0;
   obs_q_t        q2;
   obs_q_t        q0;
   vec_t          tbl [28];

   seq_11010_tx_if #(.WIDTH(W), .REP_W(RW)) if2 ();
   seq_11010_tx_if #(.WIDTH(W), .REP_W(RW)) if0 ();

   assign if2.start = start;
   assign if2.pattern = pattern;
   assign if2.reps = reps;
   assign if2.abort = abort;
   assign if0.start = start;
   assign if0.pattern = pattern;
   assign if0.reps = reps;
   assign if0.abort = abort;

   seq_11010_tx #(.WIDTH(W), .REP_W(RW), .GAP_CYCLES(2)) dut (
      .clk(clk), .reset_n(reset_n), .bus(if2)
   );
   seq_11010_tx #(.WIDTH(W), .REP_W(RW), .GAP_CYCLES(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(if0)
   );

   always #5 clk = ~clk;

   function automatic obs_q_t build(input logic [W-1:0] p, input logic [RW-1:0] n, input int gap);
      obs_q_t r;
      int nn = int'(n);
      for (int k = 0; k < nn; k++) begin
         for (int b = W - 1; b >= 0; b--) r.push_back({p[b], 3'b110});
         if (k < nn - 1) for (int g = 0; g < gap; g++) r.push_back(4'b0010);
      end
      r.push_back(4'b0011);
      return r;
   endfunction

   // Front of the queue is the current cycle; empty means IDLE.
   function automatic obs_q_t advance(input obs_q_t q, input int gap);
      obs_q_t r = q;
      if (r.size() != 0) begin
         void'(r.pop_front());
         if (abort) r.delete();
      end else if (start) begin
         r = build(pattern, reps, gap);
      end
      return r;
   endfunction

   function automatic obs_t head(input obs_q_t q);
      return (q.size() != 0) ? q[0] : 4'b0000;
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %b want %b", name, edge_n, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      edge_n++;
      q2 = advance(q2, 2);
      q0 = advance(q0, 0);
      #1;
      check("model_gap2", {if2.a_out, if2.bit_valid, if2.busy, if2.done}, head(q2));
      check("model_gap0", {if0.a_out, if0.bit_valid, if0.busy, if0.done}, head(q0));
   endtask

   // Done cycles are relative to the accepting edge T; bits/detections from the GAP=0 instance.
   task automatic run_frame(input logic [W-1:0] p, input logic [RW-1:0] n,
                            output int t2, output int t0, output int nb0, output int det0);
      logic [W-1:0] win;
      int t;
      t2 = -1; t0 = -1; nb0 = 0; det0 = 0; win = 5'b00000;
      start = 1'b1; pattern = p; reps = n;
      step();
      t = edge_n - 1;
      start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (if2.done) t2 = edge_n - t;
         if (if0.done) t0 = edge_n - t;
         if (if0.bit_valid) begin
            nb0++;
            win = {win[W-2:0], if0.a_out};
            if (nb0 >= W && win == 5'b11010) det0++;
         end
         if (!if2.busy && !if0.busy) break;
         step();
      end
      check("frame_end_busy", {2'b00, if2.busy, if0.busy}, 4'b0000);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      int t2, t0, nb, det;
      tbl[0]  = '{1'b1, 5'b11010, 4'd1, 1'b0, 4'b1110};
      tbl[1]  = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b1110};
      tbl[2]  = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0110};
      tbl[3]  = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b1110};
      tbl[4]  = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0110};
      tbl[5]  = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0011};
      tbl[6]  = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0000};
      tbl[7]  = '{1'b1, 5'b11010, 4'd0, 1'b0, 4'b0011};
      tbl[8]  = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0000};
      tbl[9]  = '{1'b1, 5'b11010, 4'd2, 1'b0, 4'b1110};
      tbl[10] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b1110};
      tbl[11] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0110};
      tbl[12] = '{1'b0, 5'b00000, 4'd0, 1'b1, 4'b0000};
      tbl[13] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0000};
      tbl[14] = '{1'b1, 5'b10110, 4'd1, 1'b0, 4'b1110};
      tbl[15] = '{1'b1, 5'b00000, 4'd3, 1'b0, 4'b0110};
      tbl[16] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b1110};
      tbl[17] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b1110};
      tbl[18] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0110};
      tbl[19] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0011};
      tbl[20] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0000};
      tbl[21] = '{1'b1, 5'b11010, 4'd1, 1'b1, 4'b1110};
      tbl[22] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b1110};
      tbl[23] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0110};
      tbl[24] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b1110};
      tbl[25] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0110};
      tbl[26] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0011};
      tbl[27] = '{1'b0, 5'b00000, 4'd0, 1'b0, 4'b0000};

      start = 1'b0; abort = 1'b0; pattern = 5'b00000; reps = 4'd0;
      reset_n = 1'b0;
      #3;
      check("reset_gap2", {if2.a_out, if2.bit_valid, if2.busy, if2.done}, 4'b0000);
      check("reset_gap0", {if0.a_out, if0.bit_valid, if0.busy, if0.done}, 4'b0000);
      #9 reset_n = 1'b1;
      repeat (3) step();

      for (int i = 0; i < 28; i++) begin
         start = tbl[i].st; pattern = tbl[i].pat; reps = tbl[i].rp; abort = tbl[i].ab;
         step();
         check($sformatf("vec%0d", i), {if2.a_out, if2.bit_valid, if2.busy, if2.done}, tbl[i].exp);
      end
      start = 1'b0; abort = 1'b0;

      run_frame(5'b11010, 4'd3, t2, t0, nb, det);
      check_int("rep3_done_gap2", t2, 20);
      check_int("rep3_done_gap0", t0, 16);
      check_int("rep3_detect_gap0", det, 3);
      run_frame(5'b11010, 4'd2, t2, t0, nb, det);
      check_int("rep2_done_gap2", t2, 13);
      check_int("rep2_done_gap0", t0, 11);
      check_int("rep2_bits_gap0", nb, 10);
      check_int("rep2_detect_gap0", det, 2);
      run_frame(5'b10011, 4'd0, t2, t0, nb, det);
      check_int("rep0_done_gap2", t2, 1);
      check_int("rep0_bits_gap0", nb, 0);
      run_frame(5'b11010, 4'd15, t2, t0, nb, det);
      check_int("rep15_done_gap2", t2, 104);
      check_int("rep15_done_gap0", t0, 76);

      // Reset asserted between clock edges in the middle of a frame.
      start = 1'b1; pattern = 5'b11010; reps = 4'd2;
      step();
      start = 1'b0;
      step();
      step();
      #2 reset_n = 1'b0;
      #1;
      check("async_reset_gap2", {if2.a_out, if2.bit_valid, if2.busy, if2.done}, 4'b0000);
      check("async_reset_gap0", {if0.a_out, if0.bit_valid, if0.busy, if0.done}, 4'b0000);
      q2.delete();
      q0.delete();
      @(posedge clk);
      #3 reset_n = 1'b1;
      repeat (4) step();

      for (int i = 0; i < 800; i++) begin
         start   = ($urandom_range(0, 3) == 0);
         pattern = W'($urandom);
         reps    = ($urandom_range(0, 9) == 0) ? 4'd15 : RW'($urandom_range(0, 4));
         abort   = ($urandom_range(0, 19) == 0);
         step();
      end
      start = 1'b0; abort = 1'b0;
      repeat (120) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
